// File: rtl/serial_bus_bridge.sv
// serial_bus_bridge
// Takes one CPU bus transaction at a time over a valid/ready handshake and
// serialises it onto narrow pin lanes, LSB beat first:
//   ADDR  (ADDR_W/LANE_W beats on pin_out, pin_frame on beat 0)
//   CMD   (one beat on pin_out carrying the write flag)
//   WDATA (DATA_W/LANE_W beats driven on pio_out) or TURN (one idle cycle)
//   WAIT  (until pin_ack)
//   RDATA (DATA_W/LANE_W beats captured from pio_in, reads only)
//   DONE  (one-cycle rsp_valid pulse)
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   req_valid/req_ready      request handshake; req_we/req_addr/req_wdata
//   rsp_valid/rsp_rdata/rsp_err  one-cycle response
//   busy                     high whenever not IDLE
//   pin_out, pin_frame       dedicated output lane
//   pio_out, pio_oe, pio_in  bidirectional lane
//   pin_ack                  external device acknowledge
// Optional feature: define SERIAL_BUS_TIMEOUT_EN to abort a WAIT lasting
// TIMEOUT cycles with rsp_err = 1 and rsp_rdata = all ones.
// All outputs are registered copies of the decode of the next state, so they
// line up exactly with the registered state.

module serial_bus_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LANE_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [LANE_W-1:0] pin_out,
    output logic              pin_frame,
    output logic [LANE_W-1:0] pio_out,
    output logic [LANE_W-1:0] pio_oe,
    input  logic [LANE_W-1:0] pio_in,
    input  logic              pin_ack
);

    localparam int A_BEATS   = ADDR_W / LANE_W;
    localparam int D_BEATS   = DATA_W / LANE_W;
    localparam int MAX_BEATS = (A_BEATS > D_BEATS) ? A_BEATS : D_BEATS;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_CMD   = 3'd2,
        ST_WDATA = 3'd3,
        ST_TURN  = 3'd4,
        ST_WAIT  = 3'd5,
        ST_RDATA = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic                we_r, we_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [DATA_W-1:0]   wdata_r, wdata_s;
    logic [DATA_W-1:0]   rdata_r, rdata_s;
    logic                err_s;

    logic                req_ready_s, busy_s, pin_frame_s, rsp_valid_s, rsp_err_s;
    logic [LANE_W-1:0]   pin_out_s, pio_out_s, pio_oe_s;
    logic [DATA_W-1:0]   rsp_rdata_s;

`ifdef SERIAL_BUS_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0]   wait_r, wait_s;
    logic                err_r;
`else
    logic                unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT > 0);
`endif

    // Next-state, beat counter, request latch and read-data capture.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        we_s    = we_r;
        addr_s  = addr_r;
        wdata_s = wdata_r;
        rdata_s = rdata_r;
`ifdef SERIAL_BUS_TIMEOUT_EN
        wait_s  = wait_r;
        err_s   = err_r;
`else
        err_s   = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    we_s    = req_we;
                    addr_s  = req_addr;
                    wdata_s = req_wdata;
                    rdata_s = {DATA_W{1'b0}};
                    err_s   = 1'b0;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ST_ADDR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (cnt_r == CNT_W'(A_BEATS - 1)) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ST_CMD;
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_CMD: begin
                cnt_s   = {CNT_W{1'b0}};
`ifdef SERIAL_BUS_TIMEOUT_EN
                wait_s  = {WAIT_W{1'b0}};
`endif
                state_s = we_r ? ST_WDATA : ST_TURN;
            end
            ST_WDATA: begin
                if (cnt_r == CNT_W'(D_BEATS - 1)) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ST_WAIT;
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_TURN: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                // An acknowledge on the final allowed cycle still completes normally.
                if (pin_ack) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = we_r ? ST_DONE : ST_RDATA;
                end else begin
`ifdef SERIAL_BUS_TIMEOUT_EN
                    if (wait_r == WAIT_W'(TIMEOUT - 1)) begin
                        err_s   = 1'b1;
                        state_s = ST_DONE;
                    end else begin
                        wait_s  = wait_r + WAIT_W'(1);
                    end
`else
                    state_s = ST_WAIT;
`endif
                end
            end
            ST_RDATA: begin
                for (int k = 0; k < D_BEATS; k++) begin
                    if (cnt_r == CNT_W'(k)) begin
                        rdata_s[k*LANE_W +: LANE_W] = pio_in;
                    end else begin
                        rdata_s[k*LANE_W +: LANE_W] = rdata_r[k*LANE_W +: LANE_W];
                    end
                end
                if (cnt_r == CNT_W'(D_BEATS - 1)) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ST_DONE;
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output decode of the next state; registered below so pins follow the state register.
    always_comb begin
        req_ready_s = (state_s == ST_IDLE);
        busy_s      = (state_s != ST_IDLE);
        pin_out_s   = {LANE_W{1'b0}};
        pin_frame_s = 1'b0;
        pio_out_s   = {LANE_W{1'b0}};
        pio_oe_s    = {LANE_W{1'b0}};
        rsp_valid_s = 1'b0;
        rsp_err_s   = 1'b0;
        rsp_rdata_s = {DATA_W{1'b0}};
        case (state_s)
            ST_ADDR: begin
                for (int k = 0; k < A_BEATS; k++) begin
                    if (cnt_s == CNT_W'(k)) begin
                        pin_out_s = addr_s[k*LANE_W +: LANE_W];
                    end else begin
                        pin_out_s = pin_out_s;
                    end
                end
                pin_frame_s = (cnt_s == {CNT_W{1'b0}});
            end
            ST_CMD: begin
                pin_out_s = LANE_W'(we_s);
            end
            ST_WDATA: begin
                pio_oe_s = {LANE_W{1'b1}};
                for (int k = 0; k < D_BEATS; k++) begin
                    if (cnt_s == CNT_W'(k)) begin
                        pio_out_s = wdata_s[k*LANE_W +: LANE_W];
                    end else begin
                        pio_out_s = pio_out_s;
                    end
                end
            end
            ST_DONE: begin
                rsp_valid_s = 1'b1;
                rsp_err_s   = err_s;
                if (err_s) begin
                    rsp_rdata_s = {DATA_W{1'b1}};
                end else if (we_s) begin
                    rsp_rdata_s = {DATA_W{1'b0}};
                end else begin
                    rsp_rdata_s = rdata_s;
                end
            end
            default: begin
                pin_out_s = {LANE_W{1'b0}};
            end
        endcase
    end

    // State, transaction context and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            we_r      <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
            rdata_r   <= {DATA_W{1'b0}};
`ifdef SERIAL_BUS_TIMEOUT_EN
            wait_r    <= {WAIT_W{1'b0}};
            err_r     <= 1'b0;
`endif
            req_ready <= 1'b1;
            busy      <= 1'b0;
            pin_out   <= {LANE_W{1'b0}};
            pin_frame <= 1'b0;
            pio_out   <= {LANE_W{1'b0}};
            pio_oe    <= {LANE_W{1'b0}};
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= {DATA_W{1'b0}};
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            we_r      <= we_s;
            addr_r    <= addr_s;
            wdata_r   <= wdata_s;
            rdata_r   <= rdata_s;
`ifdef SERIAL_BUS_TIMEOUT_EN
            wait_r    <= wait_s;
            err_r     <= err_s;
`endif
            req_ready <= req_ready_s;
            busy      <= busy_s;
            pin_out   <= pin_out_s;
            pin_frame <= pin_frame_s;
            pio_out   <= pio_out_s;
            pio_oe    <= pio_oe_s;
            rsp_valid <= rsp_valid_s;
            rsp_err   <= rsp_err_s;
            rsp_rdata <= rsp_rdata_s;
        end
    end

endmodule

// File: tb/tb_serial_bus_bridge.sv
// Directed bench for serial_bus_bridge: a 32/32/8 instance and a 16/8/4 instance.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Cycle c means the c-th cycle after the acceptance edge.

module tb_serial_bus_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req_valid = 1'b0, req_we = 1'b0, pin_ack = 1'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, rsp_valid, rsp_err, busy, pin_frame;
    logic [31:0] rsp_rdata;
    logic [7:0]  pin_out, pio_out, pio_oe;
    logic [7:0]  pio_in = 8'h00;

    logic        req_valid1 = 1'b0, req_we1 = 1'b0, pin_ack1 = 1'b0;
    logic [15:0] req_addr1 = 16'h0;
    logic [7:0]  req_wdata1 = 8'h0;
    logic        req_ready1, rsp_valid1, rsp_err1, busy1, pin_frame1;
    logic [7:0]  rsp_rdata1;
    logic [3:0]  pin_out1, pio_out1, pio_oe1;
    logic [3:0]  pio_in1 = 4'h0;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]  po_log [0:63];
    logic [7:0]  pio_log[0:63];
    logic [7:0]  oe_log [0:63];
    logic        fr_log [0:63];
    int          done_cyc;
    logic [31:0] done_rdata;
    logic        done_err;
    logic        busy_ok;

    always #5 clk = ~clk;

    serial_bus_bridge #(.ADDR_W(32), .DATA_W(32), .LANE_W(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .pin_out(pin_out), .pin_frame(pin_frame),
        .pio_out(pio_out), .pio_oe(pio_oe), .pio_in(pio_in), .pin_ack(pin_ack)
    );

    serial_bus_bridge #(.ADDR_W(16), .DATA_W(8), .LANE_W(4), .TIMEOUT(15)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
        .req_addr(req_addr1), .req_wdata(req_wdata1),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
        .busy(busy1), .pin_out(pin_out1), .pin_frame(pin_frame1),
        .pio_out(pio_out1), .pio_oe(pio_oe1), .pio_in(pio_in1), .pin_ack(pin_ack1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction on the 32/32/8 instance. pin_ack is high from cycle
    // ack_from onward (0 = already high); read beats of rd_pat are driven
    // starting in cycle rstart. Request inputs are scrambled after acceptance.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_from, input int rstart, input logic [31:0] rd_pat,
                           input int max_cyc);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        pin_ack = (ack_from == 0);
        done_cyc = -1; busy_ok = 1'b1; done_rdata = 32'h0; done_err = 1'b0;
        for (int c = 1; c <= max_cyc && done_cyc < 0; c++) begin
            @(negedge clk);
            req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
            po_log[c] = pin_out; pio_log[c] = pio_out; oe_log[c] = pio_oe; fr_log[c] = pin_frame;
            if (rsp_valid === 1'b1) begin
                done_cyc = c; done_rdata = rsp_rdata; done_err = rsp_err;
            end else if (busy !== 1'b1 || req_ready !== 1'b0) begin
                busy_ok = 1'b0;
            end
            pin_ack = (c >= ack_from);
            if (c >= rstart && c < rstart + 4) begin
                pio_in = rd_pat[(c - rstart)*8 +: 8];
            end else begin
                pio_in = 8'h00;
            end
        end
        pin_ack = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_ready", {63'd0, req_ready}, 64'd1);
        chk("reset_outs", {busy, pin_frame, rsp_valid, rsp_err, pin_out, pio_out, pio_oe, rsp_rdata},
            {4'b0000, 8'h00, 8'h00, 8'h00, 32'h0});
        rst_n = 1'b1;
        @(negedge clk);

        // Write 0x12345678 <- 0xCAFEBABE, ack already high
        run_txn(1'b1, 32'h1234_5678, 32'hCAFE_BABE, 0, 100, 32'h0, 40);
        chk("wr_pin_out", {24'd0, po_log[1], po_log[2], po_log[3], po_log[4], po_log[5]},
            {24'd0, 40'h78_56_34_12_01});
        chk("wr_frame", {59'd0, fr_log[1], fr_log[2], fr_log[3], fr_log[4], fr_log[5]}, 64'b10000);
        chk("wr_pio_out", {32'd0, pio_log[6], pio_log[7], pio_log[8], pio_log[9]}, 64'hBE_BA_FE_CA);
        chk("wr_pio_oe", {oe_log[5], oe_log[6], oe_log[7], oe_log[8], oe_log[9], oe_log[10]},
            64'h00_FF_FF_FF_FF_00);
        chk("wr_latency", done_cyc, 64'd11);
        chk("wr_rsp", {done_err, done_rdata}, 64'd0);
        @(negedge clk);
        chk("wr_ready_after_done", {62'd0, req_ready, busy}, 64'b10);

        // Read 0x10, device returns 0xDEADBEEF
        run_txn(1'b0, 32'h0000_0010, 32'h0, 0, 8, 32'hDEAD_BEEF, 40);
        chk("rd_pin_out", {24'd0, po_log[1], po_log[2], po_log[3], po_log[4], po_log[5]},
            {24'd0, 40'h10_00_00_00_00});
        chk("rd_turn_oe", {56'd0, oe_log[6]}, 64'h00);
        chk("rd_rdata", {31'd0, done_err, done_rdata}, 64'hDEAD_BEEF);
        chk("rd_latency", done_cyc, 64'd12);

        // Read with acknowledge withheld: five WAIT cycles in total
        run_txn(1'b0, 32'h0000_0020, 32'h0, 11, 12, 32'h0123_4567, 40);
        chk("rd_wait_latency", done_cyc, 64'd16);
        chk("rd_wait_busy", {63'd0, busy_ok}, 64'd1);
        chk("rd_wait_rdata", {32'd0, done_rdata}, 64'h0123_4567);

        // Reset during WDATA beat 2
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0044; req_wdata = 32'h1122_3344;
        pin_ack = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("rst_pre_beat2", {48'd0, pio_oe, pio_out}, 64'hFF_22);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_idle", {rsp_valid, req_ready, busy, pio_oe}, {3'b010, 8'h00});
        rst_n = 1'b1;
        busy_ok = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) busy_ok = 1'b0;
        end
        chk("rst_no_rsp", {63'd0, busy_ok}, 64'd1);
        run_txn(1'b0, 32'h0000_0010, 32'h0, 0, 8, 32'hA5A5_0F0F, 40);
        chk("rst_fresh_rd", {31'd0, done_err, done_rdata}, 64'hA5A5_0F0F);
        chk("rst_fresh_lat", done_cyc, 64'd12);

        // Read with no acknowledge at all
`ifdef SERIAL_BUS_TIMEOUT_EN
        run_txn(1'b0, 32'h0000_0030, 32'h0, 1000, 1000, 32'h0, 60);
        chk("to_latency", done_cyc, 64'd22);
        chk("to_rsp", {31'd0, done_err, done_rdata}, {31'd0, 1'b1, 32'hFFFF_FFFF});
`else
        run_txn(1'b0, 32'h0000_0030, 32'h0, 1000, 1000, 32'h0, 40);
        chk("noack_holds", done_cyc, -64'sd1);
        chk("noack_busy", {62'd0, busy, req_ready}, 64'b10);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif

        // 16/8/4 instance: write 0xA5C3 <- 0x7E
        pin_ack1 = 1'b1;
        req_valid1 = 1'b1; req_we1 = 1'b1; req_addr1 = 16'hA5C3; req_wdata1 = 8'h7E;
        done_cyc = -1;
        for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
            @(negedge clk);
            req_valid1 = 1'b0; req_addr1 = 16'h0000; req_wdata1 = 8'h00;
            po_log[c] = {4'h0, pin_out1}; pio_log[c] = {4'h0, pio_out1};
            if (rsp_valid1 === 1'b1) done_cyc = c;
        end
        chk("p_pin_out", {44'd0, po_log[1][3:0], po_log[2][3:0], po_log[3][3:0], po_log[4][3:0],
            po_log[5][3:0]}, 64'h3C5A1);
        chk("p_pio_out", {56'd0, pio_log[6][3:0], pio_log[7][3:0]}, 64'hE7);
        chk("p_latency", done_cyc, 64'd9);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
